mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side stage driven by control_module's IorD/IRWrite/MemWrite strobes. Selects PC or ALUOut as the
//  address, runs a req/ready handshake to a variable-latency memory, loads IR or MDR, and decodes IR fields
//  (Op_code/Funct feed control_module). Drives mem_stall so the control FSM holds its state while an access
//  is in flight.
// PARAMETERS
//  N        32  data/address width
//  TIMEOUT  15  max cycles mem_req may wait for mem_ready before the access is aborted
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  IRWrite    in   1   instruction fetch request (read into IR)
//  MemRead    in   1   data read request (read into MDR)
//  MemWrite   in   1   data write request
//  IorD       in   1   address select: 0=pc, 1=alu_out
//  pc         in   N   program counter
//  alu_out    in   N   ALUOut register (data address)
//  reg_b      in   N   B register (store data)
//  mem_req    out  1   memory request, held until mem_ready
//  mem_we     out  1   write qualifier for mem_req
//  mem_addr   out  N   latched access address
//  mem_wdata  out  N   latched store data
//  mem_rdata  in   N   read data, valid when mem_ready=1
//  mem_ready  in   1   memory completion, one-cycle pulse
//  instr      out  N   instruction register
//  mdr        out  N   memory data register
//  Op_code    out  6   instr[31:26]
//  Funct      out  6   instr[5:0]
//  rs,rt,rd   out  5   instr[25:21],[20:16],[15:11]
//  shamt      out  5   instr[10:6]
//  imm        out  16  instr[15:0]
//  mem_stall  out  1   access pending; control FSM must not advance
//  mem_err    out  1   one-cycle pulse: misaligned, conflicting or timed-out access
// BEHAVIOUR
//  Reset: state=IDLE; mem_req=mem_we=mem_err=0; mem_addr=mem_wdata=0; instr=0 (sll $0 = NOP); mdr=0; counter=0.
//  States: IDLE, REQ, DONE.
//  IDLE: mem_stall = (IRWrite|MemRead|MemWrite) combinationally.
//   - Any strobe: latch addr=(IorD?alu_out:pc), wdata=reg_b, kind={IR,MDR,WR}.
//   - Kind priority: IRWrite > MemWrite > MemRead. More than one strobe set -> highest wins, mem_err pulses
//     the next cycle, access still proceeds.
//   - Address with addr[1:0]!=0: no access. mem_err=1 next cycle, stay IDLE, IR/MDR unchanged.
//   - Otherwise go to REQ.
//  REQ: mem_req=1; mem_we=(kind==WR); mem_stall=1. Address and data are stable for the whole state.
//   - mem_ready in the same cycle as the first mem_req is legal.
//   - On mem_ready: IR kind -> instr<=mem_rdata; MDR kind -> mdr<=mem_rdata; WR kind loads nothing.
//     mem_req drops the next cycle. Go to DONE.
//   - Timeout counter counts REQ cycles. If it reaches TIMEOUT without mem_ready: mem_req drops, mem_err
//     pulses, nothing is loaded, go to IDLE.
//  DONE: mem_stall=0 for one cycle so the control FSM advances. Strobes are ignored here, so one held strobe
//   cannot start a duplicate access. Return to IDLE.
//  Latency: request-to-release = mem latency + 2 cycles minimum (IDLE->REQ, ready, DONE).
//  mem_ready outside REQ is ignored.
//  Decode outputs are combinational slices of instr. They update the cycle after instr loads.
//  rst during REQ: mem_req deasserts at that edge and the access is abandoned. Memory must tolerate a
//   dropped request.
// STRUCTURE
//  mips_mem_defines.v (`include): state codes MEM_IDLE/MEM_REQ/MEM_DONE, kind codes, IR field bit positions.
//  Sub-module mem_timeout_counter: clear/enable/expired at TIMEOUT. Everything else is inline.
// TESTING
//  1. Fetch: IRWrite=1, IorD=0, pc=0x40; memory returns 0x012A4020 after 3 cycles -> instr=0x012A4020,
//     Op_code=0, Funct=0x20, rd=8; mem_stall low exactly one cycle (DONE); only one mem_req burst.
//  2. Store: MemWrite=1, IorD=1, alu_out=0x100, reg_b=0xDEADBEEF; zero-latency ready -> one cycle with
//     mem_req=mem_we=1, addr=0x100, wdata=0xDEADBEEF; instr and mdr unchanged.
//  3. Misaligned load: MemRead=1, alu_out=0x102 -> mem_req never asserts; mem_err pulses once;
//     mdr keeps its old value.
//  4. Timeout: IRWrite with mem_ready held 0 -> mem_req high 15 cycles then low; mem_err pulse;
//     instr unchanged; FSM back in IDLE.
//  5. Reset mid-access: assert rst during REQ cycle 2 -> next cycle mem_req=0, instr=0, state=IDLE;
//     a late mem_ready is ignored.
//  6. Conflict: IRWrite=MemWrite=1 -> read into IR performed, mem_we=0, mem_err pulse.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access stage: FSM states, access kinds and
// instruction field positions used by the decode slices.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    KIND_IR  = 2'd0,
    KIND_MDR = 2'd1,
    KIND_WR  = 2'd2
  } mem_kind_e;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  // Fetch beats store, store beats load when control raises several strobes.
  function automatic mem_kind_e select_kind(input logic ir_wr, input logic mem_rd,
                                            input logic mem_wr);
    mem_kind_e k;
    k = KIND_MDR;
    if (ir_wr) k = KIND_IR;
    else if (mem_wr) k = KIND_WR;
    else if (mem_rd) k = KIND_MDR;
    return k;
  endfunction

  function automatic logic multi_strobe(input logic ir_wr, input logic mem_rd,
                                        input logic mem_wr);
    return (ir_wr & mem_rd) | (ir_wr & mem_wr) | (mem_rd & mem_wr);
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles an access has been waiting; expired is high during the
// TIMEOUT-th enabled cycle so the FSM can abort on that edge.
module mem_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage: picks PC or ALUOut, runs one req/ready access to a
// variable-latency memory, loads IR or MDR and decodes the IR fields.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IRWrite,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         IorD,
  input  logic [N-1:0] pc,
  input  logic [N-1:0] alu_out,
  input  logic [N-1:0] reg_b,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] mdr,
  output logic [5:0]   Op_code,
  output logic [5:0]   Funct,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [15:0]  imm,
  output logic         mem_stall,
  output logic         mem_err,
  output mem_state_e   dbg_state
);

  // Handshake: mem_req rises with address/data/we already stable and stays
  // high until a cycle in which mem_ready=1 is sampled (that cycle included);
  // mem_ready is only honoured while in MEM_REQ and is a single-cycle pulse.

  mem_state_e   state_q, state_d;
  mem_kind_e    kind_q, kind_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic [N-1:0] instr_q, instr_d;
  logic [N-1:0] mdr_q, mdr_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic         err_q, err_d;

  logic         any_strobe;
  logic [N-1:0] sel_addr;
  mem_kind_e    sel_kind;
  logic         tmo_clear;
  logic         tmo_en;
  logic         tmo_expired;

  assign any_strobe = IRWrite | MemRead | MemWrite;
  assign sel_addr   = IorD ? alu_out : pc;
  assign sel_kind   = select_kind(IRWrite, MemRead, MemWrite);

  mem_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    instr_d   = instr_q;
    mdr_d     = mdr_q;
    req_d     = req_q;
    we_d      = we_q;
    err_d     = 1'b0;
    tmo_clear = 1'b1;
    tmo_en    = 1'b0;

    case (state_q)
      MEM_IDLE: begin
        if (any_strobe) begin
          addr_d  = sel_addr;
          wdata_d = reg_b;
          kind_d  = sel_kind;
          // A misaligned word address never reaches the memory bus.
          if (sel_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            state_d = MEM_REQ;
            req_d   = 1'b1;
            we_d    = (sel_kind == KIND_WR);
            err_d   = multi_strobe(IRWrite, MemRead, MemWrite);
          end
        end
      end
      MEM_REQ: begin
        tmo_clear = 1'b0;
        tmo_en    = 1'b1;
        if (mem_ready) begin
          if (kind_q == KIND_IR)  instr_d = mem_rdata;
          if (kind_q == KIND_MDR) mdr_d   = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = MEM_DONE;
        end else if (tmo_expired) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = MEM_IDLE;
        end
      end
      MEM_DONE: begin
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      kind_q  <= KIND_IR;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      mdr_q   <= mdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // DONE releases the stall for exactly one cycle regardless of held strobes.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      MEM_IDLE: mem_stall = any_strobe;
      MEM_REQ:  mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;
  assign instr     = instr_q;
  assign mdr       = mdr_q;
  assign dbg_state = state_q;

  assign Op_code = instr_q[OP_MSB:OP_LSB];
  assign rs      = instr_q[RS_MSB:RS_LSB];
  assign rt      = instr_q[RT_MSB:RT_LSB];
  assign rd      = instr_q[RD_MSB:RD_LSB];
  assign shamt   = instr_q[SHAMT_MSB:SHAMT_LSB];
  assign Funct   = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign imm     = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random accesses, with a
// responder memory and an event scoreboard checked by a separate monitor.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int EV_REQ  = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          ev;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
    logic [31:0] instr;
    logic [31:0] mdr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        IRWrite, MemRead, MemWrite, IorD;
  logic [31:0] pc, alu_out, reg_b;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] resp_rdata;
  logic        resp_ready;
  logic        late_ready;
  logic        mem_ready;
  logic [31:0] instr, mdr;
  logic [5:0]  Op_code, Funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        mem_stall, mem_err;
  mem_state_e  dbg_state;

  exp_t        exp_q[$];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] ref_instr, ref_mdr;
  int          cur_lat;
  int          checks;
  int          failures;
  bit          mon_en;

  assign mem_ready = resp_ready | late_ready;

  always #5 clk = ~clk;

  mem_access_unit #(.N(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .pc(pc), .alu_out(alu_out), .reg_b(reg_b),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(resp_rdata), .mem_ready(mem_ready), .instr(instr), .mdr(mdr),
    .Op_code(Op_code), .Funct(Funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .mem_stall(mem_stall), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  function automatic logic [31:0] dflt_word(input logic [31:0] a);
    return (a * 32'h0019_660D) + 32'h3C6E_F35F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int ev, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input int len);
    exp_t r;
    r.ev = ev; r.addr = addr; r.we = we; r.wdata = wdata; r.len = len;
    r.instr = ref_instr; r.mdr = ref_mdr;
    exp_q.push_back(r);
  endtask

  task automatic pop_ev(input int ev, output exp_t rec, output bit ok);
    ok = 1'b0;
    rec.ev = -1; rec.addr = '0; rec.we = 1'b0; rec.wdata = '0; rec.len = 0;
    rec.instr = '0; rec.mdr = '0;
    checks++;
    if (exp_q.size() == 0 || exp_q[0].ev != ev) begin
      failures++;
      $display("FAIL event_order actual_event=%0d required_event=%0d at %0t", ev,
               (exp_q.size() == 0) ? -1 : exp_q[0].ev, $time);
    end else begin
      rec = exp_q.pop_front();
      ok = 1'b1;
    end
  endtask

  // Responder memory: raises ready in the (cur_lat+1)-th cycle of a request.
  initial begin
    int req_cycles;
    req_cycles = 0;
    resp_ready = 1'b0;
    resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && rst === 1'b0) begin
        req_cycles++;
        if (req_cycles == cur_lat + 1) begin
          resp_ready = 1'b1;
          resp_rdata = resp_mem.exists(mem_addr) ? resp_mem[mem_addr] : dflt_word(mem_addr);
          if (mem_we === 1'b1) resp_mem[mem_addr] = mem_wdata;
        end else begin
          resp_ready = 1'b0;
          resp_rdata = $urandom;
        end
      end else begin
        req_cycles = 0;
        resp_ready = 1'b0;
        resp_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a request, error or release.
  initial begin
    bit   prev_req, req_now, ok;
    int   burst_len, exp_len;
    exp_t r;
    prev_req = 1'b0; burst_len = 0; exp_len = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        req_now = (mem_req === 1'b1);
        if (req_now && !prev_req) begin
          pop_ev(EV_REQ, r, ok);
          if (ok) begin
            chk("req_addr", mem_addr, r.addr);
            chk("req_we", {31'b0, mem_we}, {31'b0, r.we});
            chk("req_wdata", mem_wdata, r.wdata);
            chk("stall_in_req", {31'b0, mem_stall}, 32'd1);
            exp_len = r.len;
          end
          burst_len = 1;
        end else if (req_now) begin
          burst_len++;
        end
        if (!req_now && prev_req) chk("req_burst_len", burst_len, exp_len);
        prev_req = req_now;
        if (mem_err === 1'b1) begin
          pop_ev(EV_ERR, r, ok);
          if (ok) begin
            chk("err_instr", instr, r.instr);
            chk("err_mdr", mdr, r.mdr);
          end
        end
        if (dbg_state == MEM_DONE) begin
          pop_ev(EV_DONE, r, ok);
          if (ok) begin
            chk("done_stall", {31'b0, mem_stall}, 32'd0);
            chk("done_instr", instr, r.instr);
            chk("done_mdr", mdr, r.mdr);
            chk("decode_fields", {Op_code, rs, rt, rd, shamt, Funct}, r.instr);
            chk("decode_imm", {16'b0, imm}, {16'b0, r.instr[15:0]});
          end
        end
      end
    end
  end

  task automatic do_access(input logic irw, input logic mrd, input logic mwr,
                           input logic iord, input logic [31:0] pcv,
                           input logic [31:0] aluv, input logic [31:0] regbv,
                           input int lat);
    logic [31:0] addr, rval;
    bit multi, mis, tmo, is_ir, is_wr, hold, done;
    addr  = iord ? aluv : pcv;
    multi = (int'(irw) + int'(mrd) + int'(mwr)) > 1;
    mis   = (addr % 4) != 0;
    tmo   = lat >= 15;
    is_ir = irw;
    is_wr = !irw && mwr;
    hold  = !mis && !tmo;
    rval  = ref_mem.exists(addr) ? ref_mem[addr] : dflt_word(addr);
    if (mis) begin
      push_ev(EV_ERR, '0, 1'b0, '0, 0);
    end else begin
      push_ev(EV_REQ, addr, is_wr, regbv, tmo ? 15 : lat + 1);
      if (multi) push_ev(EV_ERR, '0, 1'b0, '0, 0);
      if (tmo) begin
        push_ev(EV_ERR, '0, 1'b0, '0, 0);
      end else begin
        if (is_ir) ref_instr = rval;
        else if (is_wr) ref_mem[addr] = regbv;
        else ref_mdr = rval;
        push_ev(EV_DONE, '0, 1'b0, '0, 0);
      end
    end
    cur_lat = lat;
    IRWrite = irw; MemRead = mrd; MemWrite = mwr;
    IorD = iord; pc = pcv; alu_out = aluv; reg_b = regbv;
    if (!hold) begin
      step();
      IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (hold) done = (mem_stall === 1'b0);
      else done = (dbg_state == MEM_IDLE) && (mem_err === 1'b1);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_end_wait actual=no_completion required=completion_within_60 at %0t", $time);
    end
    step();
    IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0]  s;
    logic [31:0] a;
    int          lat;
    checks = 0; failures = 0; mon_en = 1'b0; cur_lat = 0; late_ready = 1'b0;
    ref_instr = '0; ref_mdr = '0;
    rst = 1'b1; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; IorD = 1'b0;
    pc = '0; alu_out = '0; reg_b = '0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, MEM_IDLE});
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    mon_en = 1'b1;
    step();

    // Fetch with latency 3 and the strobe held through release.
    ref_mem[32'h40] = 32'h012A_4020;
    resp_mem[32'h40] = 32'h012A_4020;
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3);
    chk("t1_opcode", {26'b0, Op_code}, 32'h0);
    chk("t1_funct", {26'b0, Funct}, 32'h20);
    chk("t1_rd", {27'b0, rd}, 32'd8);

    do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 0);
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 1);
    chk("load_back", mdr, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h102, 32'h0, 0);
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0, 20);
    chk("t4_state", {30'b0, dbg_state}, {30'b0, MEM_IDLE});
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h1234_5678, 2);

    // Reset during the second request cycle, then a stray ready.
    push_ev(EV_REQ, 32'h48, 1'b0, reg_b, 2);
    cur_lat = 30;
    IRWrite = 1'b1; IorD = 1'b0; pc = 32'h48;
    step();
    IRWrite = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_instr = '0; ref_mdr = '0;
    @(negedge clk);
    chk("t5_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t5_instr", instr, 32'd0);
    chk("t5_state", {30'b0, dbg_state}, {30'b0, MEM_IDLE});
    step();
    late_ready = 1'b1;
    step();
    late_ready = 1'b0;
    @(negedge clk);
    chk("t5_late_instr", instr, 32'd0);
    chk("t5_late_state", {30'b0, dbg_state}, {30'b0, MEM_IDLE});
    chk("t5_late_req", {31'b0, mem_req}, 32'd0);
    step();

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) s = 3'($urandom_range(1, 7));
      else s = 3'(1 << $urandom_range(0, 2));
      a = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      lat = ($urandom_range(0, 9) == 0) ? 15 + $urandom_range(0, 3) : $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 0)
        do_access(s[2], s[1], s[0], 1'b0, a, $urandom, $urandom, lat);
      else
        do_access(s[2], s[1], s[0], 1'b1, $urandom, a, $urandom, lat);
    end

    repeat (5) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
